// File: rtl/uart_pkg.sv
// Shared types and helpers for the framed UART receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_framed_if.sv
// Word delivery handshake between the UART receiver and its consumer.
interface uart_rx_framed_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] data_out;
    logic                 valid_out;
    logic                 ready_in;
    logic                 parity_err_out;
    logic                 frame_err_out;
    logic                 overrun_out;

    modport master (
        output data_out, valid_out, parity_err_out, frame_err_out, overrun_out,
        input  ready_in
    );

    modport slave (
        input  data_out, valid_out, parity_err_out, frame_err_out, overrun_out,
        output ready_in
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, per-bit tick counter and 3-sample majority vote.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int SAMPLE_RATE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic rx,
    input  logic run,
    input  logic start,
    output logic line,
    output logic bit_valid,
    output logic bit_value,
    output logic bit_end
);
    localparam int CW = $clog2(SAMPLE_RATE);
    localparam logic [CW-1:0] CNT_V0   = CW'(SAMPLE_RATE / 2 - 1);
    localparam logic [CW-1:0] CNT_V1   = CW'(SAMPLE_RATE / 2);
    localparam logic [CW-1:0] CNT_V2   = CW'(SAMPLE_RATE / 2 + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_RATE - 1);

    logic [1:0]    sync_r;
    logic [CW-1:0] cnt_r;
    logic          v0_r;
    logic          v1_r;
    logic          tick_run_s;

    assign line       = sync_r[1];
    assign tick_run_s = run & tick;

    // Two-flop synchroniser, idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rx};
        end
    end

    // Tick counter; the start-detect tick is tick 0 of the start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (start) begin
            cnt_r <= CW'(1);
        end else if (!run) begin
            cnt_r <= {CW{1'b0}};
        end else if (tick) begin
            cnt_r <= (cnt_r == CNT_LAST) ? {CW{1'b0}} : cnt_r + CW'(1);
        end
    end

    // Capture the first two of the three centre samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_r <= 1'b0;
            v1_r <= 1'b0;
        end else begin
            if (tick_run_s && cnt_r == CNT_V0) begin
                v0_r <= line;
            end
            if (tick_run_s && cnt_r == CNT_V1) begin
                v1_r <= line;
            end
        end
    end

    // Vote result strobes on the third sample tick
    always_comb begin
        bit_valid = tick_run_s & (cnt_r == CNT_V2);
        bit_value = maj3(v0_r, v1_r, line);
        bit_end   = tick_run_s & (cnt_r == CNT_LAST);
    end

endmodule

// File: rtl/uart_rx_framed.sv
// Parametrised UART receiver: frame state machine and output word register.
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int SAMPLE_RATE = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             tick_in,
    input  logic             rx_in,
    input  logic             enable_in,
    uart_rx_framed_if.master rx_if
);
    localparam parity_t       PAR_MODE  = parity_t'(PARITY[1:0]);
    localparam logic          PAR_ON    = (PAR_MODE != PAR_NONE);
    localparam logic          PAR_INV   = (PAR_MODE == PAR_ODD);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam int            CW        = $clog2(SAMPLE_RATE);
    localparam logic [CW-1:0] BRK_LAST  = CW'(SAMPLE_RATE - 1);

    function automatic logic data_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

    logic [1:0]           rst_sync_r;
    logic                 rst_n_s;
    rx_state_t            state_r;
    rx_state_t            state_s;
    logic                 line_s;
    logic                 bit_valid_s;
    logic                 bit_value_s;
    logic                 bit_end_s;
    logic                 run_s;
    logic                 start_s;
    logic                 shift_s;
    logic                 data_done_s;
    logic                 par_chk_s;
    logic                 stop_acc_s;
    logic                 commit_s;
    logic                 brk_done_s;
    logic                 frame_err_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [3:0]           bit_idx_r;
    logic                 par_err_r;
    logic                 stop_err_r;
    logic [CW-1:0]        brk_cnt_r;
    logic [DATA_BITS-1:0] data_r;
    logic                 valid_r;
    logic                 perr_r;
    logic                 ferr_r;
    logic                 ovr_r;

    // Reset synchroniser: asynchronous assert, synchronous release
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end
    assign rst_n_s = rst_sync_r[1];

    uart_rx_sampler #(.SAMPLE_RATE(SAMPLE_RATE)) u_sampler (
        .clk       (clk_in),
        .rst_n     (rst_n_s),
        .tick      (tick_in),
        .rx        (rx_in),
        .run       (run_s),
        .start     (start_s),
        .line      (line_s),
        .bit_valid (bit_valid_s),
        .bit_value (bit_value_s),
        .bit_end   (bit_end_s)
    );

    // State register
    always_ff @(posedge clk_in or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r <= RX_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            RX_IDLE:   state_s = start_s ? RX_START : RX_IDLE;
            RX_START:  state_s = (bit_valid_s & bit_value_s) ? RX_IDLE
                               : (bit_end_s ? RX_DATA : RX_START);
            RX_DATA:   state_s = data_done_s ? (PAR_ON ? RX_PARITY : RX_STOP) : RX_DATA;
            RX_PARITY: state_s = bit_end_s ? RX_STOP : RX_PARITY;
            RX_STOP:   state_s = commit_s ? (frame_err_s ? RX_BREAK : RX_IDLE) : RX_STOP;
            RX_BREAK:  state_s = brk_done_s ? RX_IDLE : RX_BREAK;
            default:   state_s = RX_IDLE;
        endcase
    end

    // Per-state control strobes; the word commits mid last stop bit
    always_comb begin
        run_s       = 1'b0;
        start_s     = 1'b0;
        shift_s     = 1'b0;
        data_done_s = 1'b0;
        par_chk_s   = 1'b0;
        stop_acc_s  = 1'b0;
        commit_s    = 1'b0;
        brk_done_s  = 1'b0;
        frame_err_s = stop_err_r | ~bit_value_s;
        case (state_r)
            RX_IDLE:   start_s = tick_in & enable_in & ~line_s;
            RX_START:  run_s = 1'b1;
            RX_DATA: begin
                run_s       = 1'b1;
                shift_s     = bit_valid_s;
                data_done_s = bit_end_s & (bit_idx_r == DATA_LAST);
            end
            RX_PARITY: begin
                run_s     = 1'b1;
                par_chk_s = bit_valid_s;
            end
            RX_STOP: begin
                run_s      = 1'b1;
                stop_acc_s = bit_valid_s & (bit_idx_r != STOP_LAST);
                commit_s   = bit_valid_s & (bit_idx_r == STOP_LAST);
            end
            RX_BREAK:  brk_done_s = tick_in & line_s & (brk_cnt_r == BRK_LAST);
            default:   run_s = 1'b0;
        endcase
    end

    // Frame datapath: LSB-first shifter, bit index, accumulated errors
    always_ff @(posedge clk_in or negedge rst_n_s) begin
        if (!rst_n_s) begin
            shift_r    <= {DATA_BITS{1'b0}};
            bit_idx_r  <= 4'd0;
            par_err_r  <= 1'b0;
            stop_err_r <= 1'b0;
        end else if (start_s) begin
            bit_idx_r  <= 4'd0;
            par_err_r  <= 1'b0;
            stop_err_r <= 1'b0;
        end else if (shift_s) begin
            shift_r   <= {bit_value_s, shift_r[DATA_BITS-1:1]};
            bit_idx_r <= bit_idx_r + 4'd1;
        end else if (data_done_s) begin
            bit_idx_r <= 4'd0;
        end else if (par_chk_s) begin
            par_err_r <= bit_value_s ^ data_parity(shift_r) ^ PAR_INV;
        end else if (stop_acc_s) begin
            stop_err_r <= stop_err_r | ~bit_value_s;
            bit_idx_r  <= bit_idx_r + 4'd1;
        end
    end

    // Consecutive high ticks seen while recovering from a break
    always_ff @(posedge clk_in or negedge rst_n_s) begin
        if (!rst_n_s) begin
            brk_cnt_r <= {CW{1'b0}};
        end else if (state_r != RX_BREAK) begin
            brk_cnt_r <= {CW{1'b0}};
        end else if (tick_in) begin
            brk_cnt_r <= line_s ? brk_cnt_r + CW'(1) : {CW{1'b0}};
        end
    end

    // Output word register; a commit into a full, unaccepted slot is dropped
    always_ff @(posedge clk_in or negedge rst_n_s) begin
        if (!rst_n_s) begin
            data_r  <= {DATA_BITS{1'b0}};
            valid_r <= 1'b0;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            ovr_r <= 1'b0;
            if (commit_s && (!valid_r || rx_if.ready_in)) begin
                data_r  <= shift_r;
                valid_r <= 1'b1;
                perr_r  <= PAR_ON & par_err_r;
                ferr_r  <= frame_err_s;
            end else if (commit_s) begin
                ovr_r <= 1'b1;
            end else if (valid_r && rx_if.ready_in) begin
                valid_r <= 1'b0;
            end
        end
    end

    assign rx_if.data_out       = data_r;
    assign rx_if.valid_out      = valid_r;
    assign rx_if.parity_err_out = perr_r;
    assign rx_if.frame_err_out  = ferr_r;
    assign rx_if.overrun_out    = ovr_r;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Scoreboard bench: an 8N1 receiver and a 7O2 receiver driven with directed and random frames.
module tb_uart_rx_framed;
    localparam int SR       = 16;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLK  = SR * TICK_DIV;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic tick = 1'b0;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;
    logic en = 1'b1;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   ov_a = 0;
    int   ov_b = 0;
    int   rdy_a = 1;
    int   rdy_b = 1;

    uart_rx_framed_if #(.DATA_BITS(8)) ifa ();
    uart_rx_framed_if #(.DATA_BITS(7)) ifb ();

    uart_rx_framed #(.SAMPLE_RATE(SR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .tick_in(tick), .rx_in(rx_a),
        .enable_in(en), .rx_if(ifa)
    );

    uart_rx_framed #(.SAMPLE_RATE(SR), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .tick_in(tick), .rx_in(rx_b),
        .enable_in(en), .rx_if(ifb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic set_line(input bit to_b, input logic v);
        if (to_b) rx_b = v;
        else      rx_a = v;
    endtask

    // Build a frame from the format rules, push its expectation, then drive it
    task automatic send(input bit to_b, input logic [8:0] d, input bit bad_par,
                        input bit [1:0] bad_stop, input bit expect_it);
        int   nb;
        bit   bits[$];
        exp_t e;
        nb = to_b ? 7 : 8;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) bits.push_back(d[i]);
        if (to_b) bits.push_back((($countones(d[6:0]) % 2) == 0) ^ bad_par);
        bits.push_back(!bad_stop[0]);
        if (to_b) bits.push_back(!bad_stop[1]);
        if (expect_it) begin
            e.d  = to_b ? {2'b00, d[6:0]} : {1'b0, d[7:0]};
            e.pe = to_b & bad_par;
            e.fe = bad_stop[0] | (to_b & bad_stop[1]);
            if (to_b) qb.push_back(e);
            else      qa.push_back(e);
        end
        foreach (bits[i]) begin
            set_line(to_b, bits[i]);
            idle(BIT_CLK);
        end
        set_line(to_b, 1'b1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 3000 && (qa.size() + qb.size()) != 0; i++) @(posedge clk);
        chk(name, qa.size() + qb.size(), 0);
        idle(20);
    endtask

    // Oversampling tick: one clock high every TICK_DIV clocks
    initial begin
        int c;
        c = 0;
        forever begin
            @(posedge clk);
            #1;
            c = (c + 1) % TICK_DIV;
            tick = (c == 0);
        end
    end

    // Consumer ready: 0 = stalled, 1 = always ready, 2 = random
    initial begin
        ifa.ready_in = 1'b1;
        ifb.ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ifa.ready_in = (rdy_a == 2) ? 1'($urandom_range(0, 1)) : (rdy_a == 1);
            ifb.ready_in = (rdy_b == 2) ? 1'($urandom_range(0, 1)) : (rdy_b == 1);
        end
    end

    // Monitors: compare each accepted word against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (ifa.overrun_out) ov_a++;
        if (ifb.overrun_out) ov_b++;
        if (ifa.valid_out && ifa.ready_in) begin
            if (qa.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL a_unexpected: got word 0x%0h, required none", ifa.data_out);
            end else begin
                e = qa.pop_front();
                chk("a_data", 32'(ifa.data_out), 32'(e.d));
                chk("a_parity_err", 32'(ifa.parity_err_out), 32'(e.pe));
                chk("a_frame_err", 32'(ifa.frame_err_out), 32'(e.fe));
            end
        end
        if (ifb.valid_out && ifb.ready_in) begin
            if (qb.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL b_unexpected: got word 0x%0h, required none", ifb.data_out);
            end else begin
                e = qb.pop_front();
                chk("b_data", 32'(ifb.data_out), 32'(e.d));
                chk("b_parity_err", 32'(ifb.parity_err_out), 32'(e.pe));
                chk("b_frame_err", 32'(ifb.frame_err_out), 32'(e.fe));
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         ov0;
        logic [7:0] d99;
        logic [8:0] rd;
        bit [1:0]   rs;
        bit         rp;

        #2 rst_n = 1'b0;
        #21;
        chk("rst_a_valid", 32'(ifa.valid_out), 32'd0);
        chk("rst_a_data", 32'(ifa.data_out), 32'd0);
        chk("rst_a_flags", {29'd0, ifa.parity_err_out, ifa.frame_err_out, ifa.overrun_out}, 32'd0);
        chk("rst_b_valid", 32'(ifb.valid_out), 32'd0);
        chk("rst_b_data", 32'(ifb.data_out), 32'd0);
        #30 rst_n = 1'b1;
        idle(20);

        // 8N1 single frame
        send(1'b0, 9'h027, 1'b0, 2'b00, 1'b1);
        idle(150);
        drain("t1_drain");

        // Back-to-back with a stalled consumer: second word dropped
        rdy_a = 0;
        ov0 = ov_a;
        send(1'b0, 9'h027, 1'b0, 2'b00, 1'b1);
        idle(150);
        send(1'b0, 9'h0C3, 1'b0, 2'b00, 1'b0);
        idle(150);
        chk("t2_held_valid", 32'(ifa.valid_out), 32'd1);
        chk("t2_held_data", 32'(ifa.data_out), 32'h27);
        chk("t2_overrun_pulses", ov_a - ov0, 32'd1);
        rdy_a = 1;
        drain("t2_drain");

        // Odd parity with a wrong parity bit
        send(1'b1, 9'h027, 1'b1, 2'b00, 1'b1);
        idle(150);
        drain("t3_drain");

        // False starts on both lines, then clean frames
        rx_a = 1'b0; rx_b = 1'b0;
        idle(16);
        rx_a = 1'b1; rx_b = 1'b1;
        idle(120);
        send(1'b0, 9'h05A, 1'b0, 2'b00, 1'b1);
        idle(150);
        send(1'b1, 9'h05A, 1'b0, 2'b00, 1'b1);
        idle(150);
        drain("t4_drain");

        // Framing error into a break with a short high blip, then recovery
        send(1'b1, 9'h04B, 1'b0, 2'b10, 1'b1);
        rx_b = 1'b0;
        idle(3 * BIT_CLK);
        rx_b = 1'b1;
        idle(32);
        rx_b = 1'b0;
        idle(BIT_CLK);
        rx_b = 1'b1;
        idle(150);
        send(1'b1, 9'h015, 1'b0, 2'b00, 1'b1);
        idle(150);
        drain("t5_drain");

        // enable low ignores a whole frame
        en = 1'b0;
        send(1'b0, 9'h066, 1'b0, 2'b00, 1'b0);
        idle(150);
        en = 1'b1;
        idle(20);
        chk("en_no_word", 32'(ifa.valid_out), 32'd0);

        // Reset during data bit 4 with a word held in the output register
        rdy_a = 0;
        send(1'b0, 9'h03C, 1'b0, 2'b00, 1'b1);
        idle(150);
        chk("t6_pre_valid", 32'(ifa.valid_out), 32'd1);
        d99 = 8'h99;
        rx_a = 1'b0;
        idle(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rx_a = d99[i];
            idle(BIT_CLK);
        end
        rx_a = d99[4];
        idle(BIT_CLK / 2);
        ov0 = ov_a;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(ifa.valid_out), 32'd0);
        chk("t6_rst_data", 32'(ifa.data_out), 32'd0);
        chk("t6_rst_flags", {29'd0, ifa.parity_err_out, ifa.frame_err_out, ifa.overrun_out}, 32'd0);
        qa.delete();
        idle(5);
        rx_a = 1'b1;
        rst_n = 1'b1;
        idle(200);
        chk("t6_no_overrun", ov_a - ov0, 32'd0);
        chk("t6_idle_valid", 32'(ifa.valid_out), 32'd0);
        rdy_a = 1;
        send(1'b0, 9'h081, 1'b0, 2'b00, 1'b1);
        idle(150);
        drain("t6_drain");

        // Randomised frames with a randomly stalling consumer
        rdy_a = 2;
        rdy_b = 2;
        ov0 = ov_a + ov_b;
        for (int n = 0; n < 16; n++) begin
            rd = 9'($urandom_range(0, 255));
            rs = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00;
            send(1'b0, rd, 1'b0, rs, 1'b1);
            idle(140 + $urandom_range(0, 40));
            rd = 9'($urandom_range(0, 127));
            rp = ($urandom_range(0, 5) == 0);
            rs = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            send(1'b1, rd, rp, rs, 1'b1);
            idle(140 + $urandom_range(0, 40));
        end
        drain("rand_drain");
        chk("rand_no_overrun", ov_a + ov_b - ov0, 32'd0);
        chk("ov_total_b", ov_b, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
